// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, defaults and helpers for the FIFO write-port arbiter.
// Optional statistics counters are enabled with the FWA_STATS_EN macro.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_e;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;
   localparam int DEF_CNT_W     = 16;
   localparam int ONEHOT_W      = 32;

   // Wide one-hot; callers size-cast it down to their requester count.
   function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
      logic [ONEHOT_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
// stat_cnt_o exists only when FWA_STATS_EN is defined.
interface fifo_wr_arbiter_if
   import fifo_wr_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   logic [N_REQ-1:0]         req_i;
   logic [N_REQ*WIDTH-1:0]   wdata_i;
   logic                     full_i;
   logic [N_REQ-1:0]         gnt_o;
   logic [N_REQ-1:0]         ack_o;
   logic                     wr_en_o;
   logic [WIDTH-1:0]         wdata_o;
   logic                     busy_o;
   logic [$clog2(N_REQ)-1:0] owner_o;
`ifdef FWA_STATS_EN
   logic [N_REQ*CNT_W-1:0]   stat_cnt_o;
`endif

   modport master (
      output req_i, wdata_i, full_i,
      input  gnt_o, ack_o, wr_en_o, wdata_o, busy_o, owner_o
`ifdef FWA_STATS_EN
      , input stat_cnt_o
`endif
   );

   modport slave (
      input  req_i, wdata_i, full_i,
      output gnt_o, ack_o, wr_en_o, wdata_o, busy_o, owner_o
`ifdef FWA_STATS_EN
      , output stat_cnt_o
`endif
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin finder: first requester after rrPtr_i, wrapping
// modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rrPtr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] sel_o
);

   logic [IDX_W-1:0] cand;

   // Scan farthest-first so the nearest requester after the pointer wins.
   always_comb begin
      valid_o = |req_i;
      sel_o   = '0;
      cand    = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = IDX_W'((int'(rrPtr_i) + i) % N_REQ);
         if (req_i[cand]) begin
            sel_o = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
// Define FWA_STATS_EN to add per-requester saturating accepted-beat counters.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = DEF_CNT_W
) (
   input logic                clk_i,
   input logic                rst_n_i,
   fifo_wr_arbiter_if.slave   bus
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

   arbState_e         state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
   logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;

   logic              pickValid;
   logic [IDX_W-1:0]  pickSel;
   logic              ownerReq;
   logic              wrEn;
   logic [N_REQ-1:0]  ackVec;
   logic [WIDTH-1:0]  wdataMux;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (bus.req_i),
      .rrPtr_i (rrPtr_q),
      .valid_o (pickValid),
      .sel_o   (pickSel)
   );

   // gnt_q is zero outside GRANT, so every write-side output is gated by it.
   always_comb begin
      ownerReq = |(gnt_q & bus.req_i);
      wrEn     = ownerReq & ~bus.full_i;
      ackVec   = gnt_q & {N_REQ{wrEn}};
      wdataMux = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_q[k]) begin
            wdataMux = wdataMux | bus.wdata_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.gnt_o   = gnt_q;
   assign bus.ack_o   = ackVec;
   assign bus.wr_en_o = wrEn;
   assign bus.wdata_o = wdataMux;
   assign bus.busy_o  = (state_q == GRANT);
   assign bus.owner_o = owner_q;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      rrPtr_d   = rrPtr_q;
      beatCnt_d = beatCnt_q;
      unique case (state_q)
         IDLE: begin
            if (pickValid) begin
               state_d   = GRANT;
               gnt_d     = N_REQ'(onehot(int'(pickSel)));
               owner_d   = pickSel;
               beatCnt_d = '0;
            end
         end
         GRANT: begin
            if (!ownerReq || (wrEn && beatCnt_q == LAST_BEAT)) begin
               state_d   = IDLE;
               gnt_d     = '0;
               rrPtr_d   = owner_q;
               beatCnt_d = '0;
            end else if (wrEn) begin
               beatCnt_d = beatCnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= LAST_IDX;
         rrPtr_q   <= LAST_IDX;
         beatCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         rrPtr_q   <= rrPtr_d;
         beatCnt_q <= beatCnt_d;
      end
   end

`ifdef FWA_STATS_EN
   logic [N_REQ-1:0][CNT_W-1:0] statCnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         statCnt_q <= '0;
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (ackVec[k] && (statCnt_q[k] != {CNT_W{1'b1}})) begin
               statCnt_q[k] <= statCnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign bus.stat_cnt_o = statCnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; stats checks build with FWA_STATS_EN.
module tb_fifo_wr_arbiter;
   import fifo_wr_arb_pkg::*;

   localparam int N_REQ     = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;
`ifdef FWA_STATS_EN
   localparam int CNT_W     = 3;
`else
   localparam int CNT_W     = 16;
`endif

   logic clk;
   logic rst_n;
   int   testsRun  = 0;
   int   failCount = 0;

   int   remaining [N_REQ];
   int   dataCnt   [N_REQ];
   logic fullReq;
   logic [WIDTH-1:0] expQ [N_REQ][$];

   fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   fifo_wr_arbiter #(
      .N_REQ     (N_REQ),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] dataOf(input int k, input int n);
      return WIDTH'((k << 6) | (n & 63));
   endfunction

   // Requester model drives its head-of-line data while it still has beats.
   task automatic drive();
      bus.full_i = fullReq;
      for (int k = 0; k < N_REQ; k++) begin
         bus.req_i[k] = (remaining[k] > 0);
         bus.wdata_i[k*WIDTH +: WIDTH] = dataOf(k, dataCnt[k]);
      end
   endtask

   task automatic load(input int k, input int n);
      for (int i = 0; i < n; i++) expQ[k].push_back(dataOf(k, dataCnt[k] + i));
      remaining[k] += n;
      drive();
   endtask

   task automatic clearModel();
      for (int k = 0; k < N_REQ; k++) begin
         remaining[k] = 0;
         dataCnt[k]   = 0;
         expQ[k].delete();
      end
      fullReq = 1'b0;
      drive();
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle();
      logic [N_REQ-1:0] a;
      a = bus.ack_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++) begin
         if (a[k]) begin
            remaining[k]--;
            dataCnt[k]++;
         end
      end
      drive();
      @(negedge clk);
   endtask

   task automatic applyReset();
      #1;
      rst_n = 1'b0;
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int  budget;
      bit  pending;
      budget  = 200;
      pending = 1'b1;
      while (pending && budget > 0) begin
         pending = 1'b0;
         for (int k = 0; k < N_REQ; k++)
            if (remaining[k] > 0 || expQ[k].size() > 0) pending = 1'b1;
         if (pending) begin
            cycle();
            budget--;
         end
      end
      testsRun++;
      if (pending) begin
         failCount++;
         $display("[TB] FAIL drain_timeout: requests still pending after 200 cycles, required none");
      end
      repeat (2) cycle();
   endtask

   // Scoreboard: every accepted beat must match the owner's next expected word.
   int monIdx;
   logic [WIDTH-1:0] monExp;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.full_i === 1'b1) begin
            testsRun++;
            if (bus.wr_en_o !== 1'b0) begin
               failCount++;
               $display("[TB] FAIL full_guard: wr_en_o=%b while full_i=1, required 0", bus.wr_en_o);
            end
         end
         if (bus.wr_en_o === 1'b1) begin
            monIdx = int'(bus.owner_o);
            testsRun++;
            if (expQ[monIdx].size() == 0) begin
               failCount++;
               $display("[TB] FAIL unexpected_write: owner %0d wrote %h, required no write", monIdx, bus.wdata_o);
            end else begin
               monExp = expQ[monIdx].pop_front();
               if (bus.wdata_o !== monExp || bus.ack_o !== N_REQ'(1 << monIdx)) begin
                  failCount++;
                  $display("[TB] FAIL beat_data: owner %0d wdata=%h ack=%b, required wdata=%h ack=%b",
                           monIdx, bus.wdata_o, bus.ack_o, monExp, N_REQ'(1 << monIdx));
               end
            end
         end else if (bus.ack_o !== '0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL ack_no_write: ack_o=%b with wr_en_o=0, required 0000", bus.ack_o);
         end
      end
   end

   task automatic test_reset();
      applyReset();
      testsRun++;
      if (bus.gnt_o !== '0 || bus.wr_en_o !== 1'b0 || bus.ack_o !== '0 ||
          bus.wdata_o !== '0 || bus.busy_o !== 1'b0 || bus.owner_o !== 2'd3) begin
         failCount++;
         $display("[TB] FAIL reset_values: gnt=%b wr=%b ack=%b wdata=%h busy=%b owner=%0d, required 0000 0 0000 00 0 3",
                  bus.gnt_o, bus.wr_en_o, bus.ack_o, bus.wdata_o, bus.busy_o, bus.owner_o);
      end
   endtask

   task automatic test_single_burst();
      bit expWr  [10] = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 0};
      bit expG0  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 0};
      int pulses = 0;
      load(0, 6);
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (bus.wr_en_o === 1'b1) pulses++;
         testsRun++;
         if (bus.wr_en_o !== expWr[c] || bus.gnt_o !== {3'b000, expG0[c]}) begin
            failCount++;
            $display("[TB] FAIL single_burst c%0d: wr=%b gnt=%b, required wr=%b gnt=000%b",
                     c + 1, bus.wr_en_o, bus.gnt_o, expWr[c], expG0[c]);
         end
      end
      testsRun++;
      if (pulses != 6 || expQ[0].size() != 0) begin
         failCount++;
         $display("[TB] FAIL single_total: pulses=%0d left=%0d, required 6 and 0", pulses, expQ[0].size());
      end
   endtask

   task automatic test_round_robin();
      int g, ph;
      logic [N_REQ-1:0] expG;
      applyReset();
      for (int k = 0; k < N_REQ; k++) load(k, 8);
      for (int c = 1; c <= 25; c++) begin
         cycle();
         g    = (c - 1) / 5;
         ph   = (c - 1) % 5;
         expG = (ph < 4) ? N_REQ'(1 << (g % N_REQ)) : '0;
         testsRun++;
         if (bus.gnt_o !== expG || bus.wr_en_o !== (ph < 4)) begin
            failCount++;
            $display("[TB] FAIL rr_order c%0d: gnt=%b wr=%b, required gnt=%b wr=%b",
                     c, bus.gnt_o, bus.wr_en_o, expG, (ph < 4));
         end
         if (ph == 0) begin
            testsRun++;
            if (bus.owner_o !== 2'(g % N_REQ)) begin
               failCount++;
               $display("[TB] FAIL rr_owner c%0d: owner=%0d, required %0d", c, bus.owner_o, g % N_REQ);
            end
         end
      end
      drain();
   endtask

   task automatic test_full_stall();
      applyReset();
      load(1, 6);
      cycle();
      testsRun++;
      if (bus.gnt_o !== 4'b0010 || bus.wr_en_o !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL full_first: gnt=%b wr=%b, required 0010 1", bus.gnt_o, bus.wr_en_o);
      end
      fullReq = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         testsRun++;
         if (bus.wr_en_o !== 1'b0 || bus.ack_o !== '0 || bus.gnt_o !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL full_hold %0d: wr=%b ack=%b gnt=%b, required 0 0000 0010",
                     c, bus.wr_en_o, bus.ack_o, bus.gnt_o);
         end
         if (c == 2) fullReq = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
         cycle();
         testsRun++;
         if (bus.wr_en_o !== 1'b1 || bus.gnt_o !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL full_resume %0d: wr=%b gnt=%b, required 1 0010", c, bus.wr_en_o, bus.gnt_o);
         end
      end
      cycle();
      testsRun++;
      if (bus.gnt_o !== '0 || bus.wr_en_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL full_release: gnt=%b wr=%b, required 0000 0", bus.gnt_o, bus.wr_en_o);
      end
      drain();
   endtask

   task automatic test_early_drop();
      logic [N_REQ-1:0] expG [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
      bit expWr [5] = '{1, 1, 0, 0, 1};
      applyReset();
      load(1, 1);
      drain();
      load(2, 2);
      load(3, 4);
      load(0, 4);
      for (int c = 0; c < 5; c++) begin
         cycle();
         testsRun++;
         if (bus.gnt_o !== expG[c] || bus.wr_en_o !== expWr[c]) begin
            failCount++;
            $display("[TB] FAIL early_drop c%0d: gnt=%b wr=%b, required gnt=%b wr=%b",
                     c + 1, bus.gnt_o, bus.wr_en_o, expG[c], expWr[c]);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_burst();
      applyReset();
      load(1, 4);
      cycle();
      cycle();
      #1;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (bus.gnt_o !== '0 || bus.wr_en_o !== 1'b0 || bus.ack_o !== '0 || bus.busy_o !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_async: gnt=%b wr=%b ack=%b busy=%b, required 0000 0 0000 0",
                  bus.gnt_o, bus.wr_en_o, bus.ack_o, bus.busy_o);
      end
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < N_REQ; k++) load(k, 4);
      cycle();
      testsRun++;
      if (bus.gnt_o !== 4'b0001 || bus.owner_o !== 2'd0) begin
         failCount++;
         $display("[TB] FAIL reset_regrant: gnt=%b owner=%0d, required 0001 0", bus.gnt_o, bus.owner_o);
      end
      drain();
   endtask

`ifdef FWA_STATS_EN
   task automatic test_stats();
      logic [CNT_W-1:0] expCnt;
      applyReset();
      load(0, 10);
      drain();
      for (int k = 0; k < N_REQ; k++) begin
         expCnt = (k == 0) ? CNT_W'(7) : '0;
         testsRun++;
         if (bus.stat_cnt_o[k*CNT_W +: CNT_W] !== expCnt) begin
            failCount++;
            $display("[TB] FAIL stat_cnt[%0d]: got %0d, required %0d",
                     k, bus.stat_cnt_o[k*CNT_W +: CNT_W], expCnt);
         end
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      fullReq = 1'b0;
      clearModel();
      @(negedge clk);
      test_reset();
      test_single_burst();
      test_round_robin();
      test_full_stall();
      test_early_drop();
      test_reset_mid_burst();
`ifdef FWA_STATS_EN
      test_stats();
`endif
      testsRun++;
      for (int k = 0; k < N_REQ; k++) begin
         if (expQ[k].size() != 0) begin
            failCount++;
            $display("[TB] FAIL leftover[%0d]: %0d beats never written, required 0", k, expQ[k].size());
            break;
         end
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
